// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants and helpers for the CDB arbiter slice.
//   ROB_WIDTH_BIT       width of a ROB tag
//   CDB_FIFO_DEPTH_BIT  log2 of the per-source FIFO depth
//   CDB_SRC_*           source codes that appear on cdb_src
//   rr_pick / rr_next   round-robin search helpers
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH_BIT      = 4;
  localparam int CDB_FIFO_DEPTH_BIT = 2;

  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_LD  = 2'd1;
  localparam logic [1:0] CDB_SRC_ST  = 2'd2;

  typedef struct packed {
    logic       found;
    logic [1:0] src;
  } rr_pick_t;

  // First requesting source at or after ptr, in the order ALU -> load -> store, wrapping.
  function automatic rr_pick_t rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      idx = (int'(ptr) + i) % 3;
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.src   = idx[1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src == CDB_SRC_ST) ? CDB_SRC_ALU : src + 2'd1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer handshakes and the CDB broadcast bus.
//   alu_* / ld_* / st_*  producer offers (valid, tag, value) and FIFO ready
//   cdb_*                broadcast slot (valid, source, tag, value)
//   modport master: producer/consumer side; modport slave: the arbiter.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
  parameter int ROB_ID_W = ROB_WIDTH_BIT
);
  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [31:0]         alu_value;
  logic                alu_ready;

  logic                ld_valid;
  logic [ROB_ID_W-1:0] ld_rob_id;
  logic [31:0]         ld_value;
  logic                ld_ready;

  logic                st_valid;
  logic [ROB_ID_W-1:0] st_rob_id;
  logic                st_ready;

  logic                cdb_valid;
  logic [1:0]          cdb_src;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [31:0]         cdb_value;

  modport master (
    output alu_valid, alu_rob_id, alu_value,
    output ld_valid, ld_rob_id, ld_value,
    output st_valid, st_rob_id,
    input  alu_ready, ld_ready, st_ready,
    input  cdb_valid, cdb_src, cdb_rob_id, cdb_value
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_value,
    input  ld_valid, ld_rob_id, ld_value,
    input  st_valid, st_rob_id,
    output alu_ready, ld_ready, st_ready,
    output cdb_valid, cdb_src, cdb_rob_id, cdb_value
  );
endinterface

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: small synchronous FIFO with show-ahead read data.
//   clk_in, rst_in  clock, synchronous active-high reset
//   push, pop       write / read strobes (caller guarantees not full / not empty)
//   flush           empties the FIFO, overrides push and pop
//   din, dout       write data, head-of-queue data
//   full, count     status; count is DEPTH_BIT+1 wide
module cdb_fifo #(
  parameter int WIDTH     = 36,
  parameter int DEPTH_BIT = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic [DEPTH_BIT:0]   count
);
  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_BIT-1:0] wr_ptr;
  logic [DEPTH_BIT-1:0] rd_ptr;

  assign dout = mem[rd_ptr];
  assign full = (count == (DEPTH_BIT + 1)'(DEPTH));

  always_ff @(posedge clk_in) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin scheduler for the common data bus.
//   clk_in, rst_in  clock, synchronous active-high reset
//   rdy_in          global ready; the block is frozen when low
//   clear_all       ROB flush: empties every FIFO, drops the grant
//   bus             cdb_arbiter_if.slave: producer handshakes and CDB outputs
// Optional build macro CDB_PERF_EN adds perf_grants (grants per source) and
// perf_stall (cycles with a producer held off), cleared on reset only.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int FIFO_DEPTH_BIT = CDB_FIFO_DEPTH_BIT,
  parameter int ROB_ID_W       = ROB_WIDTH_BIT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_all,
  cdb_arbiter_if.slave      bus
`ifdef CDB_PERF_EN
  ,
  output logic [2:0][31:0]  perf_grants,
  output logic [31:0]       perf_stall
`endif
);
  localparam int DW = ROB_ID_W + 32;

  logic                    active;
  logic                    flush;
  logic [2:0]              full;
  logic [FIFO_DEPTH_BIT:0] cnt_alu, cnt_ld, cnt_st;
  logic [DW-1:0]           dout_alu, dout_ld;
  logic [ROB_ID_W-1:0]     dout_st;
  logic [2:0]              req;
  logic [2:0]              push;
  logic [2:0]              pop;
  logic                    grant;
  rr_pick_t                pick;
  logic [1:0]              rr_ptr;

  logic                    cdb_valid_q;
  logic [1:0]              cdb_src_q;
  logic [ROB_ID_W-1:0]     cdb_rob_id_q;
  logic [31:0]             cdb_value_q;

  assign active = rdy_in && !clear_all;
  assign flush  = rdy_in && clear_all;

  // ready comes from the registered count only; a same-cycle pop does not reopen a full FIFO
  assign bus.alu_ready = !full[0];
  assign bus.ld_ready  = !full[1];
  assign bus.st_ready  = !full[2];

  assign push[0] = bus.alu_valid && bus.alu_ready && active;
  assign push[1] = bus.ld_valid  && bus.ld_ready  && active;
  assign push[2] = bus.st_valid  && bus.st_ready  && active;

  assign req   = {cnt_st != '0, cnt_ld != '0, cnt_alu != '0};
  assign pick  = rr_pick(req, rr_ptr);
  assign grant = active && pick.found;

  assign pop[0] = grant && (pick.src == CDB_SRC_ALU);
  assign pop[1] = grant && (pick.src == CDB_SRC_LD);
  assign pop[2] = grant && (pick.src == CDB_SRC_ST);

  cdb_fifo #(.WIDTH(DW), .DEPTH_BIT(FIFO_DEPTH_BIT)) u_fifo_alu (
    .clk_in(clk_in), .rst_in(rst_in), .push(push[0]), .pop(pop[0]), .flush(flush),
    .din({bus.alu_rob_id, bus.alu_value}), .dout(dout_alu), .full(full[0]), .count(cnt_alu)
  );

  cdb_fifo #(.WIDTH(DW), .DEPTH_BIT(FIFO_DEPTH_BIT)) u_fifo_ld (
    .clk_in(clk_in), .rst_in(rst_in), .push(push[1]), .pop(pop[1]), .flush(flush),
    .din({bus.ld_rob_id, bus.ld_value}), .dout(dout_ld), .full(full[1]), .count(cnt_ld)
  );

  cdb_fifo #(.WIDTH(ROB_ID_W), .DEPTH_BIT(FIFO_DEPTH_BIT)) u_fifo_st (
    .clk_in(clk_in), .rst_in(rst_in), .push(push[2]), .pop(pop[2]), .flush(flush),
    .din(bus.st_rob_id), .dout(dout_st), .full(full[2]), .count(cnt_st)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr       <= CDB_SRC_ALU;
      cdb_valid_q  <= 1'b0;
      cdb_src_q    <= CDB_SRC_ALU;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
    end else if (rdy_in) begin
      if (clear_all) begin
        rr_ptr      <= CDB_SRC_ALU;
        cdb_valid_q <= 1'b0;
      end else if (pick.found) begin
        rr_ptr      <= rr_next(pick.src);
        cdb_valid_q <= 1'b1;
        cdb_src_q   <= pick.src;
        case (pick.src)
          CDB_SRC_ALU: begin
            cdb_rob_id_q <= dout_alu[DW-1:32];
            cdb_value_q  <= dout_alu[31:0];
          end
          CDB_SRC_LD: begin
            cdb_rob_id_q <= dout_ld[DW-1:32];
            cdb_value_q  <= dout_ld[31:0];
          end
          default: begin
            cdb_rob_id_q <= dout_st;
            cdb_value_q  <= '0;
          end
        endcase
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_src    = cdb_src_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_value  = cdb_value_q;

`ifdef CDB_PERF_EN
  logic stall;
  assign stall = (bus.alu_valid && !bus.alu_ready) ||
                 (bus.ld_valid  && !bus.ld_ready)  ||
                 (bus.st_valid  && !bus.st_ready);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else if (rdy_in) begin
      if (grant) perf_grants[pick.src] <= perf_grants[pick.src] + 32'd1;
      if (stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clear_all = 1'b0;

  always #5 clk_in = ~clk_in;

  cdb_arbiter_if #(.ROB_ID_W(4)) bus ();

`ifdef CDB_PERF_EN
  logic [2:0][31:0] perf_grants;
  logic [31:0]      perf_stall;
`endif

  cdb_arbiter #(.FIFO_DEPTH_BIT(2), .ROB_ID_W(4)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .clear_all(clear_all),
    .bus(bus)
`ifdef CDB_PERF_EN
    ,
    .perf_grants(perf_grants),
    .perf_stall(perf_stall)
`endif
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endfunction

  // reference model: one queue per producer, capacity 4, and a round-robin index
  typedef struct { logic [3:0] id; logic [31:0] val; } ent_t;
  ent_t q_alu[$];
  ent_t q_ld[$];
  ent_t q_st[$];
  int   rr = 0;

  localparam int K_RESET = 0, K_IDLE = 1, K_GRANT = 2, K_HOLD = 3;
  typedef struct { int kind; logic [1:0] src; logic [3:0] id; logic [31:0] val; } exp_t;
  exp_t exp_q[$];

  task automatic clear_model();
    q_alu.delete();
    q_ld.delete();
    q_st.delete();
    rr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1; rdy_in = 1'b1; clear_all = 1'b0;
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0; bus.st_valid = 1'b0;
    clear_model();
    exp_q.push_back('{K_RESET, 2'd0, 4'd0, 32'd0});
  endtask

  task automatic step(input bit av, input logic [3:0] aid, input logic [31:0] aval,
                      input bit lv, input logic [3:0] lid, input logic [31:0] lval,
                      input bit sv, input logic [3:0] sid,
                      input bit rdy, input bit clr);
    int   sz[3];
    int   w;
    int   idx;
    ent_t e;
    @(negedge clk_in);
    chk("alu_ready", {63'd0, bus.alu_ready}, {63'd0, q_alu.size() != 4});
    chk("ld_ready",  {63'd0, bus.ld_ready},  {63'd0, q_ld.size()  != 4});
    chk("st_ready",  {63'd0, bus.st_ready},  {63'd0, q_st.size()  != 4});
    rst_in = 1'b0; rdy_in = rdy; clear_all = clr;
    bus.alu_valid = av; bus.alu_rob_id = aid; bus.alu_value = aval;
    bus.ld_valid  = lv; bus.ld_rob_id  = lid; bus.ld_value  = lval;
    bus.st_valid  = sv; bus.st_rob_id  = sid;

    sz[0] = q_alu.size(); sz[1] = q_ld.size(); sz[2] = q_st.size();
    if (!rdy) begin
      exp_q.push_back('{K_HOLD, 2'd0, 4'd0, 32'd0});
    end else if (clr) begin
      clear_model();
      exp_q.push_back('{K_IDLE, 2'd0, 4'd0, 32'd0});
    end else begin
      w = -1;
      for (int i = 0; i < 3; i++) begin
        idx = (rr + i) % 3;
        if (w < 0 && sz[idx] > 0) w = idx;
      end
      if (w == 0) begin
        e = q_alu.pop_front();
        exp_q.push_back('{K_GRANT, 2'd0, e.id, e.val});
      end else if (w == 1) begin
        e = q_ld.pop_front();
        exp_q.push_back('{K_GRANT, 2'd1, e.id, e.val});
      end else if (w == 2) begin
        e = q_st.pop_front();
        exp_q.push_back('{K_GRANT, 2'd2, e.id, 32'd0});
      end else begin
        exp_q.push_back('{K_IDLE, 2'd0, 4'd0, 32'd0});
      end
      if (w >= 0) rr = (w + 1) % 3;
      if (av && sz[0] != 4) q_alu.push_back('{aid, aval});
      if (lv && sz[1] != 4) q_ld.push_back('{lid, lval});
      if (sv && sz[2] != 4) q_st.push_back('{sid, 32'd0});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // monitor: one expectation per clock edge once stimulus has started
  exp_t        m_e;
  logic [38:0] m_got;
  logic [38:0] m_last = '0;

  always @(posedge clk_in) begin
    #1;
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_got = {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_id, bus.cdb_value};
      case (m_e.kind)
        K_RESET: chk("reset_outputs", {25'd0, m_got}, 64'd0);
        K_IDLE:  chk("idle_valid", {63'd0, m_got[38]}, 64'd0);
        K_GRANT: chk("grant", {25'd0, m_got}, {25'd0, 1'b1, m_e.src, m_e.id, m_e.val});
        default: chk("frozen_hold", {25'd0, m_got}, {25'd0, m_last});
      endcase
      m_last = m_got;
    end
  end

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rob_id = '0; bus.alu_value = '0;
    bus.ld_valid  = 1'b0; bus.ld_rob_id  = '0; bus.ld_value  = '0;
    bus.st_valid  = 1'b0; bus.st_rob_id  = '0;

    do_reset();
    do_reset();
    idle(5);

    // single ALU result
    step(1, 4'd3, 32'h11, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // all three producers at once from a fresh round-robin pointer
    do_reset();
    step(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 4'd5, 1, 0);
    idle(4);

    // ALU continuously valid, load valid for 6 cycles: load FIFO fills
    for (int i = 0; i < 10; i++)
      step(1, 4'(i), 32'h100 + i, i < 6, 4'(8 + i), 32'h200 + i, 0, 0, 1, 0);
    idle(10);

    // queue ALU entries behind load traffic, then flush with a push in the same cycle
    for (int i = 0; i < 6; i++)
      step(1, 4'(i + 1), 32'h300 + i, 1, 4'(i + 9), 32'h400 + i, 0, 0, 1, 0);
    step(1, 4'hF, 32'hDEAD, 1, 4'hE, 32'hBEEF, 1, 4'hD, 1, 1);
    idle(5);

    // rdy_in low for 3 cycles mid-stream
    for (int i = 0; i < 4; i++)
      step(1, 4'(i), 32'h500 + i, 1, 4'(i + 4), 32'h600 + i, 1, 4'(i + 8), 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, 4'hC, 32'h777, 1, 4'hC, 32'h888, 1, 4'hC, 0, 1);
    idle(12);

    // randomized traffic with occasional freezes and flushes
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1), 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
    idle(14);

    @(posedge clk_in);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Schedules the common data bus (CDB) that carries completed results back to the ROB and to waiting RS/LSB entries.
- Three producers share one broadcast slot per cycle: the ALU result from the RS, load data from the LSB, and store completion from the LSB. Each producer has a small FIFO.
- Arbitration between producers is round-robin. The block applies backpressure to a producer when its FIFO is full, and flushes all state on ROB clear_all.
- Sits between rs/lsb outputs and the rob/rs/lsb wake-up inputs. It replaces the three separate result paths.

Parameters:
- FIFO_DEPTH_BIT, 2, log2 of per-source FIFO depth (depth 4).
- ROB_ID_W, `ROB_WIDTH_BIT, width of ROB tag.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global ready; block frozen when low
- clear_all  in  1  ROB mispredict flush
- alu_valid  in  1  ALU result offered
- alu_rob_id  in  ROB_ID_W  ALU destination tag
- alu_value  in  32  ALU result
- alu_ready  out  1  ALU FIFO can accept
- ld_valid  in  1  load result offered
- ld_rob_id  in  ROB_ID_W  load tag
- ld_value  in  32  load data
- ld_ready  out  1  load FIFO can accept
- st_valid  in  1  store completion offered
- st_rob_id  in  ROB_ID_W  store tag
- st_ready  out  1  store FIFO can accept
- cdb_valid  out  1  broadcast valid this cycle
- cdb_src  out  2  granted source: 0 ALU, 1 load, 2 store
- cdb_rob_id  out  ROB_ID_W  broadcast tag
- cdb_value  out  32  broadcast value; 0 for store

Behaviour:
- One clock (clk_in). Reset is synchronous, active-high (rst_in).
- Reset: all FIFOs empty, RR pointer = ALU. cdb_valid=0, cdb_src=0, cdb_rob_id=0, cdb_value=0. All *_ready=1.
- Push: an entry is accepted when x_valid && x_ready && rdy_in && !clear_all.
  - x_ready = (count_x != DEPTH), computed from the registered count only.
  - When a FIFO is full, ready stays low even if a pop happens in the same cycle.
- Latency: an entry pushed in cycle N can appear on the CDB registers at the end of cycle N+1 at the earliest. There is no combinational path from input to output.
- Arbitration each active cycle:
  - Candidates are the non-empty FIFOs.
  - Priority search starts at the RR pointer, in order ALU -> load -> store, wrapping.
  - The winner is popped into the CDB output registers with cdb_valid=1.
  - The RR pointer moves to the source after the winner.
  - If no FIFO is non-empty: cdb_valid=0, the RR pointer is unchanged, and the data registers hold.
- cdb_valid is a single-cycle pulse per entry. Back-to-back grants are allowed, giving full throughput of 1 result/cycle.
- FIFO pointers wrap modulo DEPTH. Count is DEPTH_BIT+1 wide.
- Simultaneous push and pop on the same FIFO: count unchanged, order preserved.
- clear_all (rdy_in high): all FIFOs emptied, cdb_valid=0 next cycle, RR pointer reset to ALU. Pushes in the same cycle are dropped. clear_all overrides any grant.
- rdy_in low: nothing changes state. Outputs hold their values, including cdb_valid; consumers are frozen too. clear_all is ignored while rdy_in is low.
- rst_in overrides rdy_in and clear_all.
- Store entries carry no value. cdb_value=0 when cdb_src=2.

Optional Feature:
- Macro CDB_PERF_EN.
- Defined:
  - Adds output perf_grants (3x32, packed) counting grants per source.
  - Adds output perf_stall (32) counting cycles where any x_valid && !x_ready.
  - All counters are cleared on reset only, not on clear_all, and frozen when rdy_in is low.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Add to const.v:
  - CDB_SRC_ALU / CDB_SRC_LD / CDB_SRC_ST codes (2'd0/1/2).
  - CDB_FIFO_DEPTH_BIT.
  - Reuse ROB_WIDTH_BIT.
- Sub-module cdb_fifo(WIDTH, DEPTH_BIT):
  - Synchronous FIFO with push/pop/flush, full/empty/count.
  - Instantiated three times, with WIDTH = ROB_ID_W+32 for ALU and load, and WIDTH = ROB_ID_W for store.
- Arbiter and output registers live in cdb_arbiter.

Test Plan:
- Reset, then idle for 5 cycles -> cdb_valid=0 throughout, all ready=1.
- ALU push (id 3, 0x11) in cycle 0 -> cycle 1 shows cdb_valid=1, src=0, id=3, value=0x11. Cycle 2 shows cdb_valid=0.
- ALU, load and store each push one entry in the same cycle (ids 1, 2, 5) -> three consecutive grants in order ALU, load, store. The store beat has value 0.
- Load held valid for 6 cycles while ALU is continuously valid -> grants alternate ALU/load. ld_ready drops after the FIFO holds 4 entries, and no entry is lost or duplicated.
- 4 ALU entries queued, clear_all pulsed -> next cycle cdb_valid=0, alu_ready=1, and no stale tag is ever broadcast. A push in the clear_all cycle is dropped.
- rdy_in held low for 3 cycles mid-stream -> outputs, counts and RR pointer are frozen. The sequence resumes exactly where it stopped.
